axis_rx_fifo: RTL

AXI-Stream receive-side buffer. Accepts beats from an AXI-Stream master (tdata plus tlast) into a DEPTH-entry FIFO and presents them, first-word-fall-through, to a local consumer through a simple pop interface. It sits at the slave end of the stream link, in place of the unbuffered slave. It decouples producer and consumer rates and reports buffer level and the number of complete packets held.

---
 rtl/axis_pkg.sv | 10 +
 rtl/axis_fifo_mem.sv | 24 ++
 rtl/axis_rx_fifo.sv | 79 +++++++
 3 files changed

// File: rtl/axis_pkg.sv
// Shared defaults and beat type for the AXI-Stream receive buffer.
package axis_pkg;
    localparam int AXIS_DATA_W = 8;
    localparam int AXIS_DEPTH  = 16;

    typedef struct packed {
        logic                   last;
        logic [AXIS_DATA_W-1:0] data;
    } axis_beat_t;
endpackage

// File: rtl/axis_fifo_mem.sv
// Storage array for the receive FIFO: one synchronous write port, one
// asynchronous read port so the head entry falls through to the consumer.
module axis_fifo_mem #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/axis_rx_fifo.sv
// AXI-Stream slave-side FIFO with first-word-fall-through pop interface,
// fill level and complete-packet count.
module axis_rx_fifo
    import axis_pkg::*;
#(
    parameter int DATA_W = AXIS_DATA_W,
    parameter int DEPTH  = AXIS_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              s_aclk,
    input  logic              s_resetn,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tlast,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              empty,
    output logic              full,
    output logic [AW:0]       level,
    output logic [AW:0]       pkt_cnt,
    output logic              rd_err
);
    logic [AW:0]     wp;
    logic [AW:0]     rp;
    logic [DATA_W:0] head;
    logic            push;
    logic            pop;

    // Handshake: a beat transfers on a rising edge where s_tvalid and s_tready
    // are both high; s_tready is a function of stored state only.
    assign push = s_tvalid & s_tready;
    assign pop  = rd_en & ~empty;

    // Wrap bit (MSB) distinguishes full from empty when the indices match.
    assign empty    = (wp == rp);
    assign full     = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
    assign level    = wp - rp;
    assign s_tready = ~full;

    axis_fifo_mem #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (s_aclk),
        .wr_en   (push),
        .wr_addr (wp[AW-1:0]),
        .wr_data ({s_tlast, s_tdata}),
        .rd_addr (rp[AW-1:0]),
        .rd_data (head)
    );

    assign rd_last = head[DATA_W];
    assign rd_data = head[DATA_W-1:0];

    always_ff @(posedge s_aclk or negedge s_resetn) begin
        if (!s_resetn) begin
            wp      <= '0;
            rp      <= '0;
            pkt_cnt <= '0;
            rd_err  <= 1'b0;
        end else begin
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            case ({push & s_tlast, pop & rd_last})
                2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
                2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
                default: pkt_cnt <= pkt_cnt;
            endcase
            rd_err <= rd_en & empty;
        end
    end
endmodule
